// File: rtl/io_fabric.sv
// io_fabric: decodes bus accesses into peripheral slots with handshake, timeout, decode errors and masked irq
module io_fabric #(
  parameter int NUM_SLOTS = 15,
  parameter int REG_AW = 5,
  parameter logic [NUM_SLOTS-1:0] SLOT_EN = '1,
  parameter int TIMEOUT_DEF = 255
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    bus_cs,
  input  logic                    bus_wr,
  input  logic                    bus_rd,
  input  logic [31:0]             bus_addr,
  input  logic [31:0]             bus_wr_data,
  output logic [31:0]             bus_rd_data,
  output logic                    bus_ready,
  output logic                    bus_err,
  output logic [NUM_SLOTS-1:0]    slot_cs,
  output logic [NUM_SLOTS-1:0]    slot_rd,
  output logic [NUM_SLOTS-1:0]    slot_wr,
  output logic [REG_AW-1:0]       slot_reg_addr,
  output logic [31:0]             slot_wr_data,
  input  logic [NUM_SLOTS*32-1:0] slot_rd_data,
  input  logic [NUM_SLOTS-1:0]    slot_ack,
  input  logic [NUM_SLOTS-1:0]    slot_irq,
  output logic                    irq
);
  localparam int SLOT_BITS = $clog2(NUM_SLOTS + 1);
  localparam int SW = 2 ** SLOT_BITS;
  localparam logic [SW-1:0] EN_EXT = SW'(SLOT_EN) | (SW'(1) << NUM_SLOTS);
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  state_t state, state_n;
  logic [SLOT_BITS-1:0] slot;
  logic [REG_AW-1:0] reg_a;
  logic [31:0] wdata, rdata, err_status, ctrl_rd, slot_data;
  logic rd_q, wr_q, err_q, ctrl, bad, ctrl_op, ack, expired, access_ok, unused;
  logic [15:0] cnt, timeout;
  logic [NUM_SLOTS-1:0] irq_mask;
  logic [SW-1:0] ack_ext, sel;
  logic [SW*32-1:0] rdx;
  assign ack_ext = SW'(slot_ack);
  assign rdx = (SW*32)'(slot_rd_data);
  assign sel = SW'(1) << slot;
  assign ctrl = slot == SLOT_BITS'(NUM_SLOTS);
  assign bad = (rd_q && wr_q) || !EN_EXT[slot];
  assign ctrl_op = ctrl && !bad;
  assign ack = ack_ext[slot];
  assign slot_data = rdx[{slot, 5'b0} +: 32];
  assign expired = timeout != '0 && cnt == timeout;
  assign access_ok = state == ACCESS && !bad && !ctrl;
  assign ctrl_rd = reg_a == REG_AW'(0) ? 32'(slot_irq) :
                   reg_a == REG_AW'(1) ? 32'(irq_mask) :
                   reg_a == REG_AW'(2) ? err_status :
                   reg_a == REG_AW'(3) ? {16'b0, timeout} : '0;
  assign slot_cs = access_ok || state == WAIT ? sel[NUM_SLOTS-1:0] : '0;
  assign slot_rd = access_ok && rd_q ? sel[NUM_SLOTS-1:0] : '0;
  assign slot_wr = access_ok && wr_q ? sel[NUM_SLOTS-1:0] : '0;
  assign slot_reg_addr = reg_a;
  assign slot_wr_data = wdata;
  assign bus_ready = state == RESP;
  assign bus_rd_data = bus_ready ? rdata : '0;
  assign bus_err = bus_ready && err_q;
  assign unused = ^{bus_addr[31:SLOT_BITS+REG_AW+2], bus_addr[1:0], sel[SW-1:NUM_SLOTS]};
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = bus_cs && (bus_rd || bus_wr) ? ACCESS : IDLE;
      ACCESS:  state_n = bad || ctrl || ack ? RESP : WAIT;
      WAIT:    state_n = ack || expired ? RESP : WAIT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else state <= state_n;
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot <= '0;
      reg_a <= '0;
      wdata <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      cnt <= '0;
      timeout <= 16'(TIMEOUT_DEF);
      irq_mask <= '0;
      err_status <= '0;
      rdata <= '0;
      err_q <= 1'b0;
      irq <= 1'b0;
    end else begin
      irq <= |(slot_irq & irq_mask);
      if (state == IDLE && bus_cs && (bus_rd || bus_wr)) begin
        slot <= bus_addr[SLOT_BITS+REG_AW+1:REG_AW+2];
        reg_a <= bus_addr[REG_AW+1:2];
        wdata <= bus_wr_data;
        rd_q <= bus_rd;
        wr_q <= bus_wr;
      end
      if (state == ACCESS) begin
        cnt <= 16'd1;
        err_q <= bad;
        rdata <= ctrl_op && rd_q ? ctrl_rd : access_ok && ack && rd_q ? slot_data : '0;
        if (bad && !err_status[31]) err_status <= {1'b1, 22'b0, 1'b0, 8'(slot)};
        if (ctrl_op && wr_q && reg_a == REG_AW'(1)) irq_mask <= wdata[NUM_SLOTS-1:0];
        if (ctrl_op && wr_q && reg_a == REG_AW'(2)) err_status <= '0;
        if (ctrl_op && wr_q && reg_a == REG_AW'(3)) timeout <= wdata[15:0];
      end
      if (state == WAIT) begin
        cnt <= cnt + 16'd1;
        err_q <= !ack && expired;
        rdata <= ack && rd_q ? slot_data : '0;
        if (!ack && expired && !err_status[31]) err_status <= {1'b1, 22'b0, 1'b1, 8'(slot)};
      end
    end
  end
endmodule
